// File: rtl/adc_frame_builder_if.sv
// Analysis-frame stream between adc_frame_builder and the spectral/fingerprint stage.
// Beats qualified by m_valid/m_ready; m_first/m_last mark the frame boundaries.
interface adc_frame_builder_if #(
  parameter int unsigned DATA_W = 12
) ();
  logic [DATA_W:0] m_data;
  logic            m_valid;
  logic            m_ready;
  logic            m_first;
  logic            m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_first,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_first,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/adc_frame_builder.sv
// ADC sample ring buffer emitting overlapping FRAME_LEN-sample frames advanced by HOP.
// Optional DC removal is enabled by defining DC_REMOVE_EN.
module adc_frame_builder #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FRAME_LEN  = 256,
  parameter int unsigned HOP        = 128,
  parameter int unsigned NUM_FRAMES = 0,
  parameter int unsigned DC_SHIFT   = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                adc_data_valid,
  adc_frame_builder_if.master m,
  output logic [15:0]         frame_idx,
  output logic                busy,
  output logic                overflow
);

  localparam int unsigned DEPTH  = 2 * FRAME_LEN;
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W;

  localparam logic [ADDR_W:0]  DepthPtr    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]  FrameLenPtr = (ADDR_W + 1)'(FRAME_LEN);
  localparam logic [ADDR_W:0]  HopPtr      = (ADDR_W + 1)'(HOP);
  localparam logic [ADDR_W:0]  PtrOne      = (ADDR_W + 1)'(1);
  localparam logic [CNT_W-1:0] BeatOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LastBeat    = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] BeatEnd     = CNT_W'(FRAME_LEN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StEmit = 2'd2;

  if ((FRAME_LEN < 4) || ((FRAME_LEN & (FRAME_LEN - 1)) != 0)) begin : g_bad_frame_len
    $error("FRAME_LEN must be a power of two and at least 4");
  end
  if ((HOP < 1) || (HOP > FRAME_LEN)) begin : g_bad_hop
    $error("HOP must lie in 1..FRAME_LEN");
  end
  if ((DC_SHIFT < 1) || (DC_SHIFT > 16)) begin : g_bad_dc_shift
    $error("DC_SHIFT must lie in 1..16");
  end

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   wp_q, wp_d;
  logic [ADDR_W:0]   fb_q, fb_d;
  logic [ADDR_W:0]   unread;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [31:0]       frames_left_q, frames_left_d;
  logic [15:0]       frame_idx_q, frame_idx_d;
  logic              overflow_q, overflow_d;
  logic              m_valid_q, m_valid_d;
  logic              m_first_q, m_first_d;
  logic              m_last_q, m_last_d;
  logic [DATA_W:0]   m_data_q, m_data_d;

  logic [DATA_W:0]   mem [DEPTH];
  logic [DATA_W:0]   wr_data;
  logic [ADDR_W-1:0] rd_addr;

  logic active, sample_in, full, wr_en, handshake, frame_done, issue, start_ok;

  // Pointers carry one extra bit so a full ring (DEPTH unread) differs from an empty one.
  assign unread     = wp_q - fb_q;
  assign full       = (unread == DepthPtr);
  assign active     = (state_q != StIdle);
  assign start_ok   = (state_q == StIdle) && start && !stop;
  assign sample_in  = active && adc_data_valid && !stop;
  assign wr_en      = sample_in && !full;
  assign handshake  = m_valid_q && m.m_ready;
  assign frame_done = handshake && m_last_q;
  assign issue      = (state_q == StEmit) && (beat_q != BeatEnd) &&
                      (!m_valid_q || m.m_ready) && !stop;
  assign rd_addr    = fb_q[ADDR_W-1:0] + beat_q;

`ifdef DC_REMOVE_EN
  localparam int unsigned ACC_W = DATA_W + DC_SHIFT;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             dc_first_q, dc_first_d;
  logic [DATA_W:0]  dc_diff;

  assign dc_diff = {1'b0, adc_data} - {1'b0, acc_q[ACC_W-1:DC_SHIFT]};
  assign wr_data = dc_first_q ? '0 : dc_diff;

  always_comb begin
    acc_d      = acc_q;
    dc_first_d = dc_first_q;
    if (start_ok) begin
      dc_first_d = 1'b1;
    end else if (wr_en) begin
      dc_first_d = 1'b0;
      // First sample seeds the tracker so the capture starts at zero output.
      acc_d = dc_first_q ? {adc_data, {DC_SHIFT{1'b0}}}
                         : acc_q + {{(DC_SHIFT - 1){dc_diff[DATA_W]}}, dc_diff};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q      <= '0;
      dc_first_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      dc_first_q <= dc_first_d;
    end
  end
`else
  assign wr_data = {1'b0, adc_data};
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wp_q[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_comb begin
    state_d       = state_q;
    wp_d          = wp_q;
    fb_d          = fb_q;
    beat_d        = beat_q;
    frames_left_d = frames_left_q;
    frame_idx_d   = frame_idx_q;
    overflow_d    = overflow_q;
    m_valid_d     = m_valid_q;
    m_first_d     = m_first_q;
    m_last_d      = m_last_q;
    m_data_d      = m_data_q;

    if (wr_en) begin
      wp_d = wp_q + PtrOne;
    end
    if (sample_in && full) begin
      overflow_d = 1'b1;
    end

    // The output register doubles as the RAM read register; it only advances when empty
    // or being accepted, which keeps the beat stable under back-pressure.
    if (issue) begin
      m_valid_d = 1'b1;
      m_data_d  = mem[rd_addr];
      m_first_d = (beat_q == '0);
      m_last_d  = (beat_q == LastBeat);
      beat_d    = beat_q + BeatOne;
    end else if (handshake) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d       = StFill;
          wp_d          = '0;
          fb_d          = '0;
          beat_d        = '0;
          frame_idx_d   = '0;
          overflow_d    = 1'b0;
          frames_left_d = 32'(NUM_FRAMES);
        end
      end
      StFill: begin
        if (unread >= FrameLenPtr) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (frame_done) begin
          fb_d   = fb_q + HopPtr;
          beat_d = '0;
          if ((NUM_FRAMES != 0) && (frames_left_q == 32'd1)) begin
            // frame_idx keeps the index of the final frame while idle.
            frames_left_d = '0;
            state_d       = StIdle;
          end else begin
            if (NUM_FRAMES != 0) begin
              frames_left_d = frames_left_q - 32'd1;
            end
            frame_idx_d = frame_idx_q + 16'd1;
            state_d     = StFill;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (stop) begin
      state_d   = StIdle;
      m_valid_d = 1'b0;
      beat_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wp_q          <= '0;
      fb_q          <= '0;
      beat_q        <= '0;
      frames_left_q <= '0;
      frame_idx_q   <= '0;
      overflow_q    <= 1'b0;
      m_valid_q     <= 1'b0;
      m_first_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      wp_q          <= wp_d;
      fb_q          <= fb_d;
      beat_q        <= beat_d;
      frames_left_q <= frames_left_d;
      frame_idx_q   <= frame_idx_d;
      overflow_q    <= overflow_d;
      m_valid_q     <= m_valid_d;
      m_first_q     <= m_first_d;
      m_last_q      <= m_last_d;
      m_data_q      <= m_data_d;
    end
  end

  assign m.m_data   = m_data_q;
  assign m.m_valid  = m_valid_q;
  assign m.m_first  = m_first_q;
  assign m.m_last   = m_last_q;
  assign frame_idx  = frame_idx_q;
  assign busy       = active;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_adc_frame_builder.sv
// Bench for adc_frame_builder: beat table, random back-pressure against a queue model,
// overflow, frame limit, stop/start and async-reset corner sequences.
module tb_adc_frame_builder;

  localparam int unsigned DW    = 12;
  localparam int unsigned FL    = 8;
  localparam int unsigned HP    = 4;
  localparam int unsigned DEPTH = 2 * FL;
  localparam int unsigned DCS   = 4;

  typedef logic [DW:0]   word_t;
  typedef logic [DW-1:0] samp_t;
  typedef struct {
    word_t       data;
    logic        first;
    logic        last;
    logic [15:0] idx;
  } beat_vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        start_b = 1'b0;
  logic        stop_b = 1'b0;
  samp_t       adc_data = '0;
  logic        adc_data_valid = 1'b0;
  logic [15:0] frame_idx_a, frame_idx_b;
  logic        busy_a, busy_b, ovf_a, ovf_b;

  adc_frame_builder_if #(.DATA_W(DW)) ifa ();
  adc_frame_builder_if #(.DATA_W(DW)) ifb ();

  adc_frame_builder #(
    .DATA_W(DW), .FRAME_LEN(FL), .HOP(HP), .NUM_FRAMES(0), .DC_SHIFT(DCS)
  ) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .adc_data(adc_data),
    .adc_data_valid(adc_data_valid), .m(ifa), .frame_idx(frame_idx_a), .busy(busy_a),
    .overflow(ovf_a)
  );

  adc_frame_builder #(
    .DATA_W(DW), .FRAME_LEN(FL), .HOP(HP), .NUM_FRAMES(3), .DC_SHIFT(DCS)
  ) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .adc_data(adc_data),
    .adc_data_valid(adc_data_valid), .m(ifb), .frame_idx(frame_idx_b), .busy(busy_b),
    .overflow(ovf_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples stored from the current frame base onwards.
  word_t mq[$];
  int    beat_j;
  int    frame_k;
  logic  exp_ovf;
`ifdef DC_REMOVE_EN
  int    m_acc;
  bit    m_dc_first;
  word_t got[$];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: expected event did not occur within its bound", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic word_t model_xform(input samp_t x);
`ifdef DC_REMOVE_EN
    int est;
    int d;
    if (m_dc_first) begin
      m_dc_first = 1'b0;
      m_acc      = int'(x) * (2 ** DCS);
      return '0;
    end
    est   = m_acc / (2 ** DCS);
    d     = int'(x) - est;
    m_acc = m_acc + d;
    return word_t'(d);
`else
    return {1'b0, x};
`endif
  endfunction

  task automatic model_start();
    mq.delete();
    beat_j  = 0;
    frame_k = 0;
    exp_ovf = 1'b0;
`ifdef DC_REMOVE_EN
    m_acc      = 0;
    m_dc_first = 1'b1;
`endif
  endtask

  // Called once per cycle for DUT A with inputs applied, before the clock edge.
  task automatic model_cycle();
    if (ifa.m_valid && ifa.m_ready) begin
      if (beat_j < mq.size()) chk("beat_data", 32'(ifa.m_data), 32'(mq[beat_j]));
      else fail_now("beat_data_missing");
      chk("beat_first", 32'(ifa.m_first), 32'(beat_j == 0));
      chk("beat_last", 32'(ifa.m_last), 32'(beat_j == FL - 1));
      chk("beat_idx", 32'(frame_idx_a), 32'(frame_k[15:0]));
      beat_j++;
    end
    if (adc_data_valid) begin
      if (mq.size() < DEPTH) mq.push_back(model_xform(adc_data));
      else exp_ovf = 1'b1;
    end
    if (beat_j == FL) begin
      for (int i = 0; i < HP; i++) void'(mq.pop_front());
      frame_k++;
      beat_j = 0;
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    start          = 1'b0;
    stop           = 1'b0;
    start_b        = 1'b0;
    stop_b         = 1'b0;
    adc_data_valid = 1'b0;
    ifa.m_ready    = 1'b0;
    ifb.m_ready    = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic start_a();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_start();
  endtask

  beat_vec_t tbl[24];
  word_t     st[16];
  int        cyc_of[24];
  int        row, fed, hs, ramp, frames_b;
  bit        found;
  logic      pv, pr, pf, pl;
  word_t     pd;

  initial begin
    ifa.m_ready = 1'b0;
    ifb.m_ready = 1'b0;

    // Expected beats for a ramp: frame f, beat j carries sample f*HOP + j.
    model_start();
    for (int i = 0; i < 16; i++) st[i] = model_xform(samp_t'(i));
    for (int f = 0; f < 3; f++)
      for (int j = 0; j < FL; j++)
        tbl[f * FL + j] = '{st[f * HP + j], (j == 0), (j == FL - 1), 16'(f)};

    // Reset values while reset is held.
    tick();
    tick();
    chk("rst_valid", 32'(ifa.m_valid), 0);
    chk("rst_data", 32'(ifa.m_data), 0);
    chk("rst_first_last", {30'd0, ifa.m_first, ifa.m_last}, 0);
    chk("rst_frame_idx", 32'(frame_idx_a), 0);
    chk("rst_busy", {30'd0, busy_a, busy_b}, 0);
    chk("rst_overflow", {30'd0, ovf_a, ovf_b}, 0);
    reset = 1'b1;
    tick();
    adc_data_valid = 1'b1;
    tick();
    chk("idle_ignores_samples", {30'd0, busy_a, ifa.m_valid}, 0);

    // Table-driven ramp with m_ready held high.
    do_reset();
    start_a();
    ifa.m_ready = 1'b1;
    row = 0;
    fed = 0;
    for (int c = 0; c < 300 && row < 24; c++) begin
      adc_data_valid = (fed < 16);
      adc_data       = samp_t'(fed);
      if (ifa.m_valid) begin
        chk("t1_data", 32'(ifa.m_data), 32'(tbl[row].data));
        chk("t1_first", 32'(ifa.m_first), 32'(tbl[row].first));
        chk("t1_last", 32'(ifa.m_last), 32'(tbl[row].last));
        chk("t1_idx", 32'(frame_idx_a), 32'(tbl[row].idx));
        cyc_of[row] = c;
        row++;
      end
      if (adc_data_valid) fed++;
      tick();
    end
    adc_data_valid = 1'b0;
    chk("t1_beats", 32'(row), 24);
    if (row == 24)
      for (int f = 0; f < 3; f++)
        chk("t1_no_bubble", 32'(cyc_of[f * FL + FL - 1] - cyc_of[f * FL]), FL - 1);
    chk("t1_overflow", 32'(ovf_a), 0);

    // Random back-pressure and sparse input against the queue model.
    do_reset();
    start_a();
    ramp = 0;
    pv   = 1'b0;
    pr   = 1'b1;
    pd   = '0;
    pf   = 1'b0;
    pl   = 1'b0;
    for (int c = 0; c < 800; c++) begin
      ifa.m_ready    = 1'($urandom_range(0, 1));
      adc_data_valid = ($urandom_range(0, 3) == 0);
      adc_data       = samp_t'(ramp);
      if (adc_data_valid) ramp++;
      if (pv && !pr)
        chk("t2_hold", {16'd0, ifa.m_valid, ifa.m_data, ifa.m_first, ifa.m_last},
            {16'd0, 1'b1, pd, pf, pl});
      model_cycle();
      pv = ifa.m_valid;
      pr = ifa.m_ready;
      pd = ifa.m_data;
      pf = ifa.m_first;
      pl = ifa.m_last;
      tick();
    end
    adc_data_valid = 1'b0;
    chk("t2_overflow", 32'(ovf_a), 32'(exp_ovf));
    chk("t2_frame_idx", 32'(frame_idx_a), 32'(frame_k[15:0]));
    chk("t2_progress", 32'(frame_k >= 5), 1);

    // Stalled output: samples 16..19 are dropped, frame 0 still intact.
    do_reset();
    start_a();
    for (int i = 0; i < 20; i++) begin
      adc_data_valid = 1'b1;
      adc_data       = samp_t'(i);
      model_cycle();
      tick();
      if (i == 15) chk("t3_ovf_before", 32'(ovf_a), 0);
      if (i == 16) chk("t3_ovf_after", 32'(ovf_a), 1);
    end
    adc_data_valid = 1'b0;
    chk("t3_ovf_model", 32'(ovf_a), 32'(exp_ovf));
    chk("t3_stall_valid_first", {30'd0, ifa.m_valid, ifa.m_first}, 3);
    chk("t3_stall_data", 32'(ifa.m_data), 32'(mq[0]));
    ifa.m_ready = 1'b1;
    for (int c = 0; c < 40 && frame_k < 1; c++) begin
      model_cycle();
      tick();
    end
    chk("t3_frame0_done", 32'(frame_k), 1);

    // Frame limit on DUT B.
    do_reset();
    start_b = 1'b1;
    tick();
    start_b     = 1'b0;
    ifb.m_ready = 1'b1;
    frames_b    = 0;
    ramp        = 0;
    found       = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      adc_data_valid = 1'b1;
      adc_data       = samp_t'(ramp);
      ramp++;
      if (ifb.m_valid && ifb.m_last) frames_b++;
      tick();
      if (!busy_b) found = 1'b1;
    end
    if (!found) fail_now("t4_busy_fall");
    chk("t4_frames", 32'(frames_b), 3);
    chk("t4_frame_idx", 32'(frame_idx_b), 2);
    chk("t4_ovf_set", 32'(ovf_b), 1);
    tick();
    tick();
    chk("t4_idle_quiet", {30'd0, ifb.m_valid, busy_b}, 0);
    chk("t4_idx_held", 32'(frame_idx_b), 2);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("t4_restart", {13'd0, busy_b, ovf_b, frame_idx_b}, {13'd0, 1'b1, 1'b0, 16'd0});
    adc_data_valid = 1'b0;

    // stop on beat 3 of frame 1.
    do_reset();
    start_a();
    ifa.m_ready = 1'b1;
    fed   = 0;
    hs    = 0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      adc_data_valid = (fed < 16);
      adc_data       = samp_t'(fed);
      if (ifa.m_valid && hs == FL + 3) begin
        chk("t5_idx_at_stop", 32'(frame_idx_a), 1);
        stop  = 1'b1;
        found = 1'b1;
      end
      if (ifa.m_valid) hs++;
      if (adc_data_valid) fed++;
      tick();
      stop = 1'b0;
    end
    adc_data_valid = 1'b0;
    if (!found) fail_now("t5_reach_beat3");
    chk("t5_after_stop", {30'd0, ifa.m_valid, busy_a}, 0);
    tick();
    chk("t5_stays_quiet", 32'(ifa.m_valid), 0);
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    chk("t5_start_stop", 32'(busy_a), 0);

    // Async reset during EMIT.
    start_a();
    ifa.m_ready = 1'b1;
    fed   = 0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      adc_data_valid = 1'b1;
      adc_data       = samp_t'(fed + 1);
      fed++;
      if (ifa.m_valid && frame_idx_a == 16'd1) found = 1'b1;
      else tick();
    end
    if (!found) fail_now("t6_reach_frame1");
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(ifa.m_valid), 0);
    chk("t6_rst_data", 32'(ifa.m_data), 0);
    chk("t6_rst_flags", {28'd0, ifa.m_first, ifa.m_last, busy_a, ovf_a}, 0);
    chk("t6_rst_idx", 32'(frame_idx_a), 0);
    tick();
    chk("t6_rst_hold", {30'd0, ifa.m_valid, busy_a}, 0);
    adc_data_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("t6_after_release", {30'd0, ifa.m_valid, busy_a}, 0);

`ifdef DC_REMOVE_EN
    // DC tracker: flat 2048 then a step to 2148.
    do_reset();
    start_a();
    ifa.m_ready = 1'b1;
    got.delete();
    fed = 0;
    for (int c = 0; c < 120; c++) begin
      adc_data_valid = (fed < 24);
      adc_data       = (fed < 12) ? samp_t'(2048) : samp_t'(2148);
      if (ifa.m_valid) got.push_back(ifa.m_data);
      model_cycle();
      if (adc_data_valid) fed++;
      tick();
    end
    adc_data_valid = 1'b0;
    if (got.size() > 21) begin
      chk("dc_flat", 32'(got[0]), 0);
      chk("dc_step0", 32'(got[20]), 100);
      chk("dc_step1", 32'(got[21]), 94);
    end else fail_now("dc_beats");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
